// File: rtl/mem_bus_pkg.sv
// Shared definitions for the CPU byte-bus responder.
// Holds the IO window base, the IO register offsets and the IO decode helpers.
// The IO window is selected when addr[17:16] == 2'b11; addr[31:18] is ignored.
package mem_bus_pkg;

   localparam logic [31:0] IO_BASE   = 32'h0003_0000;
   localparam logic [15:0] UART_DATA = 16'h0000;
   localparam logic [15:0] UART_STAT = 16'h0001;
   localparam logic [15:0] HALT      = 16'h0004;

   typedef enum logic [1:0] {
      IO_NONE,
      IO_UART_DATA,
      IO_UART_STAT,
      IO_HALT
   } io_sel_e;

   function automatic logic is_io(input logic [31:0] addr);
      return addr[17:16] == IO_BASE[17:16];
   endfunction

   // Unmapped offsets inside the window decode to IO_NONE (ignored, reads 0).
   function automatic io_sel_e io_decode(input logic [31:0] addr);
      io_sel_e sel;
      sel = IO_NONE;
      if (is_io(addr)) begin
         case (addr[15:0])
            UART_DATA: sel = IO_UART_DATA;
            UART_STAT: sel = IO_UART_STAT;
            HALT:      sel = IO_HALT;
            default:   sel = IO_NONE;
         endcase
      end
      return sel;
   endfunction

endpackage

// File: rtl/mem_resp_tx_fifo.sv
// Synchronous show-ahead byte FIFO for the UART TX path.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   push, push_data   write request/data (dropped when full)
//   pop               read request (ignored when empty)
//   head              current head byte (valid when !empty)
//   empty             FIFO holds no bytes
//   count_next        occupancy after this cycle's push/pop
// DEPTH must be a power of two so the pointers wrap naturally.
module mem_resp_tx_fifo #(
   parameter int unsigned DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic [7:0]                 push_data,
   input  logic                       pop,
   output logic [7:0]                 head,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count_next
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [7:0]    store [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          full;
   logic          push_ok;
   logic          pop_ok;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign head    = store[rd_ptr];

   always_comb begin
      count_next = count;
      if (push_ok && !pop_ok)
         count_next = count + 1'b1;
      else if (pop_ok && !push_ok)
         count_next = count - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (push_ok)
         store[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)
            rd_ptr <= rd_ptr + 1'b1;
         count <= count_next;
      end
   end

endmodule

// File: rtl/mem_bus_responder.sv
// Memory-side responder for the CPU byte bus.
// Serves a byte RAM with one-cycle read latency, a UART TX FIFO and RX holding
// register in the IO window (addr[17:16]==2'b11), and io_buffer_full back-pressure.
// Ports:
//   clk_in, rst_in        clock, synchronous active-low reset
//   rdy_in                global ready; low freezes all state
//   mem_a/mem_wr/mem_dout CPU bus address, write strobe, write data
//   mem_din               registered read data
//   io_buffer_full        registered TX FIFO near-full flag
//   tx_data/tx_valid/tx_ready  UART TX stream (show-ahead)
//   rx_data/rx_valid/rx_ready  UART RX stream into the holding register
//   sim_halt              sticky halt request
// Optional feature: define MEM_RESP_HALT_EN to enable the halt register at
// offset 0x4; otherwise sim_halt is tied low and that write is ignored.
module mem_bus_responder
   import mem_bus_pkg::*;
#(
   parameter int unsigned RAM_AW   = 17,
   parameter int unsigned TX_DEPTH = 8
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic [31:0] mem_a,
   input  logic        mem_wr,
   input  logic [7:0]  mem_dout,
   output logic [7:0]  mem_din,
   output logic        io_buffer_full,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic        sim_halt
);

   localparam int unsigned CW = $clog2(TX_DEPTH) + 1;

   logic [7:0]        ram [2**RAM_AW];
   logic [RAM_AW-1:0] ram_addr;
   io_sel_e           sel;
   logic              acc_io;

   logic              tx_empty;
   logic [CW-1:0]     tx_count_next;
   logic              tx_push;
   logic              tx_pop;

   logic              rx_full;
   logic [7:0]        rx_hold;
   logic              rx_load;
   logic              rx_pop;

   logic              unused_addr_bits;

   assign unused_addr_bits = ^mem_a[31:18];

   assign ram_addr = mem_a[RAM_AW-1:0];
   assign sel      = io_decode(mem_a);
   assign acc_io   = is_io(mem_a);

   assign tx_valid = !tx_empty;
   assign tx_push  = rdy_in && mem_wr && (sel == IO_UART_DATA);
   assign tx_pop   = rdy_in && tx_valid && tx_ready;

   // A load can only happen when the hold register is empty, so a pop in the
   // same cycle returns 0 and the incoming byte is kept.
   assign rx_ready = !rx_full;
   assign rx_load  = rdy_in && rx_valid && !rx_full;
   assign rx_pop   = rdy_in && !mem_wr && (sel == IO_UART_DATA);

   mem_resp_tx_fifo #(
      .DEPTH(TX_DEPTH)
   ) u_tx_fifo (
      .clk        (clk_in),
      .rst_n      (rst_in),
      .push       (tx_push),
      .push_data  (mem_dout),
      .pop        (tx_pop),
      .head       (tx_data),
      .empty      (tx_empty),
      .count_next (tx_count_next)
   );

   always_ff @(posedge clk_in) begin
      if (rst_in && rdy_in && mem_wr && !acc_io)
         ram[ram_addr] <= mem_dout;
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         mem_din        <= '0;
         io_buffer_full <= 1'b0;
         rx_full        <= 1'b0;
         rx_hold        <= '0;
      end else if (rdy_in) begin
         // Two-entry margin: the CPU samples this flag a cycle late and may
         // already have one more write in flight.
         io_buffer_full <= (tx_count_next >= CW'(TX_DEPTH - 2));

         if (!mem_wr) begin
            if (acc_io) begin
               case (sel)
                  IO_UART_DATA: mem_din <= rx_full ? rx_hold : '0;
                  IO_UART_STAT: mem_din <= {7'b0, rx_full};
                  default:      mem_din <= '0;
               endcase
            end else begin
               mem_din <= ram[ram_addr];
            end
         end

         if (rx_load) begin
            rx_hold <= rx_data;
            rx_full <= 1'b1;
         end else if (rx_pop) begin
            rx_full <= 1'b0;
         end
      end
   end

`ifdef MEM_RESP_HALT_EN
   logic halt_q;

   always_ff @(posedge clk_in) begin
      if (!rst_in)
         halt_q <= 1'b0;
      else if (rdy_in && mem_wr && (sel == IO_HALT))
         halt_q <= 1'b1;
   end

   assign sim_halt = halt_q;
`else
   assign sim_halt = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_responder.sv
module tb_mem_bus_responder;

   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        rst_in;
   logic        rdy_in;
   logic [31:0] mem_a;
   logic        mem_wr;
   logic [7:0]  mem_dout;
   logic [7:0]  mem_din;
   logic        io_buffer_full;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic        sim_halt;

   always #5 clk = ~clk;

   mem_bus_responder #(
      .RAM_AW   (17),
      .TX_DEPTH (DEPTH)
   ) dut (
      .clk_in         (clk),
      .rst_in         (rst_in),
      .rdy_in         (rdy_in),
      .mem_a          (mem_a),
      .mem_wr         (mem_wr),
      .mem_dout       (mem_dout),
      .mem_din        (mem_din),
      .io_buffer_full (io_buffer_full),
      .tx_data        (tx_data),
      .tx_valid       (tx_valid),
      .tx_ready       (tx_ready),
      .rx_data        (rx_data),
      .rx_valid       (rx_valid),
      .rx_ready       (rx_ready),
      .sim_halt       (sim_halt)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   // Reference model: behaviour of the bus as seen from outside.
   logic [7:0] tx_q [$];
   logic [7:0] ram_m [int unsigned];
   bit         rx_full_m = 1'b0;
   logic [7:0] rx_hold_m = '0;
   logic [7:0] exp_din   = '0;
   bit         din_known = 1'b0;
   bit         exp_ibf   = 1'b0;
   bit         halt_m    = 1'b0;

   task automatic model_edge();
      int unsigned sz;
      bit          pre_full;
      logic [7:0]  pre_hold;
      bit          do_pop;
      bit          do_push;
      bit          io;
      logic [15:0] off;
      int unsigned ra;
      if (!rst_in) begin
         tx_q.delete();
         rx_full_m = 1'b0;
         rx_hold_m = '0;
         exp_din   = '0;
         din_known = 1'b1;
         exp_ibf   = 1'b0;
         halt_m    = 1'b0;
      end else if (rdy_in) begin
         sz       = tx_q.size();
         pre_full = rx_full_m;
         pre_hold = rx_hold_m;
         do_pop   = (sz > 0) && tx_ready;
         do_push  = 1'b0;
         io       = (mem_a[17:16] == 2'b11);
         off      = mem_a[15:0];
         ra       = int'(mem_a[16:0]);
         if (mem_wr) begin
            din_known = 1'b0;
            if (io && off == 16'h0) begin
               do_push = (sz < DEPTH);
            end else if (io && off == 16'h4) begin
`ifdef MEM_RESP_HALT_EN
               halt_m = 1'b1;
`endif
            end else if (!io) begin
               ram_m[ra] = mem_dout;
            end
         end else if (io) begin
            din_known = 1'b1;
            if (off == 16'h0) begin
               exp_din   = pre_full ? pre_hold : 8'h00;
               rx_full_m = 1'b0;
            end else if (off == 16'h1) begin
               exp_din = {7'b0, pre_full};
            end else begin
               exp_din = 8'h00;
            end
         end else if (ram_m.exists(ra)) begin
            exp_din   = ram_m[ra];
            din_known = 1'b1;
         end else begin
            din_known = 1'b0;
         end
         if (do_pop)  void'(tx_q.pop_front());
         if (do_push) tx_q.push_back(mem_dout);
         if (rx_valid && !pre_full) begin
            rx_full_m = 1'b1;
            rx_hold_m = rx_data;
         end
         exp_ibf = (tx_q.size() >= DEPTH - 2);
      end
   endtask

   task automatic compare_all();
      check("rx_ready", 32'(rx_ready), 32'(!rx_full_m));
      check("tx_valid", 32'(tx_valid), 32'(tx_q.size() > 0));
      if (tx_q.size() > 0)
         check("tx_data", 32'(tx_data), 32'(tx_q[0]));
      check("io_buffer_full", 32'(io_buffer_full), 32'(exp_ibf));
      if (din_known)
         check("mem_din", 32'(mem_din), 32'(exp_din));
      check("sim_halt", 32'(sim_halt), 32'(halt_m));
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
   endtask

   task automatic bus(input logic [31:0] a, input logic wr, input logic [7:0] d);
      mem_a    = a;
      mem_wr   = wr;
      mem_dout = d;
   endtask

   initial begin
      rst_in   = 1'b0;
      rdy_in   = 1'b1;
      tx_ready = 1'b0;
      rx_valid = 1'b0;
      rx_data  = '0;
      bus(32'h0, 1'b0, 8'h00);
      #2;
      step();
      step();
      check("reset_din", 32'(mem_din), 32'h0);
      check("reset_txv", 32'(tx_valid), 32'h0);
      check("reset_rxr", 32'(rx_ready), 32'h1);
      rst_in = 1'b1;

      // Write then immediate read-back of the same RAM byte.
      bus(32'h0000_0010, 1'b1, 8'hA5); step();
      bus(32'h0000_0010, 1'b0, 8'h00); step();
      check("ram_rd_after_wr", 32'(mem_din), 32'hA5);

      // Fill the TX FIFO past full with the consumer stalled, then drain.
      for (int i = 0; i < 9; i++) begin
         bus(32'h0003_0000, 1'b1, 8'(8'h10 + i)); step();
         if (i == 4) check("ibf_below", 32'(io_buffer_full), 32'h0);
         if (i == 5) check("ibf_at6", 32'(io_buffer_full), 32'h1);
      end
      check("fifo_head", 32'(tx_data), 32'h10);
      bus(32'h0003_0002, 1'b0, 8'h00);
      tx_ready = 1'b1;
      for (int i = 0; i < 10; i++) step();
      check("fifo_drained", 32'(tx_valid), 32'h0);
      tx_ready = 1'b0;

      // RX holding register: status, pop, status again.
      rx_valid = 1'b1; rx_data = 8'h41; step();
      rx_valid = 1'b0;
      check("rx_busy", 32'(rx_ready), 32'h0);
      bus(32'h0003_0001, 1'b0, 8'h00); step();
      check("rx_stat_full", 32'(mem_din), 32'h01);
      bus(32'h0003_0000, 1'b0, 8'h00); step();
      check("rx_data", 32'(mem_din), 32'h41);
      bus(32'h0003_0001, 1'b0, 8'h00); step();
      check("rx_stat_empty", 32'(mem_din), 32'h00);

      // rdy_in low freezes RAM, mem_din and the FIFO.
      bus(32'h0000_0020, 1'b1, 8'h11); step();
      bus(32'h0000_0020, 1'b0, 8'h00); step();
      rdy_in = 1'b0;
      bus(32'h0000_0020, 1'b1, 8'h99); step();
      bus(32'h0003_0000, 1'b1, 8'h77); step();
      check("frozen_din", 32'(mem_din), 32'h11);
      check("frozen_push", 32'(tx_valid), 32'h0);
      rdy_in = 1'b1;
      bus(32'h0000_0020, 1'b0, 8'h00); step();
      check("ram_unchanged", 32'(mem_din), 32'h11);

`ifdef MEM_RESP_HALT_EN
      bus(32'h0003_0004, 1'b1, 8'h01); step();
      check("halt_set", 32'(sim_halt), 32'h1);
      bus(32'h0000_0000, 1'b0, 8'h00); step(); step();
      check("halt_sticky", 32'(sim_halt), 32'h1);
`endif

      // Reset with bytes queued and a read in flight.
      for (int i = 0; i < 3; i++) begin
         bus(32'h0003_0000, 1'b1, 8'(8'hC0 + i)); step();
      end
      bus(32'h0000_0010, 1'b0, 8'h00);
      rst_in = 1'b0; step();
      check("rst_txv", 32'(tx_valid), 32'h0);
      check("rst_ibf", 32'(io_buffer_full), 32'h0);
      check("rst_din", 32'(mem_din), 32'h0);
      check("rst_halt", 32'(sim_halt), 32'h0);
      rst_in = 1'b1;

      // Randomized traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         logic [31:0] hi;
         hi       = $urandom() & 32'hFFFC_0000;
         rst_in   = ($urandom_range(0, 199) != 0);
         rdy_in   = ($urandom_range(0, 9) != 0);
         tx_ready = ($urandom_range(0, 2) == 0);
         rx_valid = ($urandom_range(0, 3) == 0);
         rx_data  = 8'($urandom());
         mem_wr   = $urandom_range(0, 1) == 1;
         mem_dout = 8'($urandom());
         case ($urandom_range(0, 6))
            0, 1, 2: mem_a = hi | 32'($urandom_range(0, 63));
            3, 4:    mem_a = hi | 32'h0003_0000;
            5:       mem_a = hi | 32'h0003_0001;
            default: mem_a = hi | (($urandom_range(0, 1) == 0) ? 32'h0003_0004 : 32'h0003_0002);
         endcase
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
